// File: rtl/aes_inv_shift_rows_reg.sv
// ---------------------------------------------------------------------------
// aes_inv_shift_rows_reg
// Registered AES InvShiftRows stage for the decryption datapath. The 128-bit
// state is viewed column-major (byte k: row k%4, column k/4, byte 0 = MSB).
// Row r is rotated right by r byte positions. The result is held in a single
// output register behind a valid/ready handshake: one cycle of latency and
// one state per cycle of throughput.
//
// Build option: define FWD_SHIFT_ROWS_EN to add an 'inverse' input.
//   inverse = 1 selects InvShiftRows.
//   inverse = 0 selects forward ShiftRows.
// Without the macro, the transform is always InvShiftRows.
//
// Parameters
//   RESET_CLEARS_DATA  1: reset also zeroes state_out
//                      0: reset clears only out_valid
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   state_in carries a valid state
//   in_ready   stage can accept this cycle (!out_valid || out_ready)
//   state_in   input AES state
//   inverse    (FWD_SHIFT_ROWS_EN only) 1 = inverse, 0 = forward
//   out_valid  state_out holds a valid result
//   out_ready  downstream accepts state_out this cycle
//   state_out  transformed state
// ---------------------------------------------------------------------------
module aes_inv_shift_rows_reg #(
   parameter bit RESET_CLEARS_DATA = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
`ifdef FWD_SHIFT_ROWS_EN
   input  logic         inverse,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out
);

   // Row r of output column c comes from input column (c - r) mod 4 for the
   // inverse transform, and from (c + r) mod 4 for the forward transform.
   function automatic logic [127:0] shift_rows(input logic [127:0] s,
                                               input logic          inv);
      logic [127:0] res;
      int           src_col;
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (inv) src_col = (c + 4 - r) % 4;
            else     src_col = (c + r) % 4;
            res[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*src_col + r) -: 8];
         end
      end
      return res;
   endfunction

   logic         inv_sel;
   logic         accept;
   logic         out_valid_d, out_valid_q;
   logic [127:0] state_out_d, state_out_q;

`ifdef FWD_SHIFT_ROWS_EN
   assign inv_sel = inverse;
`else
   assign inv_sel = 1'b1;
`endif

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign state_out = state_out_q;

   always_comb begin
      out_valid_d = out_valid_q;
      state_out_d = state_out_q;
      if (accept) begin
         // A simultaneous drain is covered here: the new result replaces the old.
         out_valid_d = 1'b1;
         state_out_d = shift_rows(state_in, inv_sel);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         if (RESET_CLEARS_DATA) state_out_q <= '0;
         else                   state_out_q <= state_out_q;
      end else begin
         out_valid_q <= out_valid_d;
         state_out_q <= state_out_d;
      end
   end

endmodule

// File: tb/tb_aes_inv_shift_rows_reg.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_shift_rows_reg
// Directed-vector bench for aes_inv_shift_rows_reg. The expected results
// were worked out by hand from the byte map. Inputs change on the falling
// edge, and outputs are sampled on the falling edge that follows each
// rising edge.
// ---------------------------------------------------------------------------
module tb_aes_inv_shift_rows_reg;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] state_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] state_out;
`ifdef FWD_SHIFT_ROWS_EN
   logic         inverse;
`endif

   int err_cnt;
   int chk_cnt;

   localparam logic [127:0] V1 = 128'h23456701cdef89ab6701234589abcdef;
   localparam logic [127:0] R1 = 128'h23ab23abcd45cd4567ef67ef89018901;
   localparam logic [127:0] V2 = 128'hcdef01ab6789234501abcdef23456789;
   localparam logic [127:0] R2 = 128'hcd45cd4567ef67ef0189018923ab23ab;
   localparam logic [127:0] V3 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] R3 = 128'h000d0a0704010e0b0805020f0c090603;
   localparam logic [127:0] ONES = {128{1'b1}};

   aes_inv_shift_rows_reg dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .state_in  (state_in),
`ifdef FWD_SHIFT_ROWS_EN
      .inverse   (inverse),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state_out (state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      err_cnt   = 0;
      chk_cnt   = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      state_in  = '0;
`ifdef FWD_SHIFT_ROWS_EN
      inverse   = 1'b1;
`endif
      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      check("rst_out_valid", {127'd0, out_valid}, 128'd0);
      check("rst_state_out", state_out, 128'd0);
      check("rst_in_ready", {127'd0, in_ready}, 128'd1);

      // basic vectors
      in_valid = 1'b1;
      state_in = V1;
      step();
      check("v1_valid", {127'd0, out_valid}, 128'd1);
      check("v1_data", state_out, R1);
      check("v1_in_ready", {127'd0, in_ready}, 128'd1);
      state_in = V2;
      step();
      check("v2_valid", {127'd0, out_valid}, 128'd1);
      check("v2_data", state_out, R2);

      // back-to-back streaming
      state_in = '0;
      step();
      check("s0_data", state_out, 128'd0);
      check("s0_in_ready", {127'd0, in_ready}, 128'd1);
      state_in = ONES;
      step();
      check("s1_data", state_out, ONES);
      check("s1_in_ready", {127'd0, in_ready}, 128'd1);
      state_in = V3;
      step();
      check("s2_data", state_out, R3);
      check("s2_valid", {127'd0, out_valid}, 128'd1);
      in_valid = 1'b0;
      state_in = V1;
      step();
      check("drain_valid", {127'd0, out_valid}, 128'd0);

      // backpressure
      in_valid = 1'b1;
      state_in = V1;
      step();
      check("bp_load", state_out, R1);
      out_ready = 1'b0;
      state_in  = V2;
      #1;
      check("bp_in_ready0", {127'd0, in_ready}, 128'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_hold_data", state_out, R1);
         check("bp_hold_valid", {127'd0, out_valid}, 128'd1);
         check("bp_hold_ready", {127'd0, in_ready}, 128'd0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", {127'd0, in_ready}, 128'd1);
      step();
      check("bp_release_data", state_out, R2);
      check("bp_release_valid", {127'd0, out_valid}, 128'd1);
      in_valid = 1'b0;
      step();
      check("bp_drain_valid", {127'd0, out_valid}, 128'd0);

      // idle with no downstream ready still accepts
      out_ready = 1'b0;
      in_valid  = 1'b1;
      state_in  = V3;
      #1;
      check("idle_in_ready", {127'd0, in_ready}, 128'd1);
      step();
      check("idle_accept", state_out, R3);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      step();

      // reset mid-operation
      in_valid = 1'b1;
      state_in = V1;
      step();
      check("mr_load", state_out, R1);
      rst      = 1'b1;
      state_in = V2;
      step();
      check("mr_valid", {127'd0, out_valid}, 128'd0);
      check("mr_data", state_out, 128'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      step();
      check("mr_post_valid", {127'd0, out_valid}, 128'd0);
      check("mr_post_ready", {127'd0, in_ready}, 128'd1);

`ifdef FWD_SHIFT_ROWS_EN
      in_valid = 1'b1;
      inverse  = 1'b0;
      state_in = R1;
      step();
      check("fwd_roundtrip", state_out, V1);
      inverse  = 1'b1;
      state_in = V1;
      step();
      check("fwd_inv_again", state_out, R1);
      in_valid = 1'b0;
      step();
`endif

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/aes_inv_shift_rows_reg.md
Name: aes_inv_shift_rows_reg

Overview:
- Registered AES InvShiftRows stage (FIPS-197) for the decryption datapath of the AES ALU.
- Takes a 128-bit state and cyclically shifts row r right by r byte positions.
- Returns the result one clock later, with a valid/ready handshake so it chains with neighbouring round stages.

Parameters:
- RESET_CLEARS_DATA, default 1: 1 = reset also zeroes state_out; 0 = reset clears only out_valid, and state_out holds its value.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  state_in carries a valid state.
- in_ready  output  1  stage can accept a state this cycle.
- state_in  input  128  input AES state.
- out_valid  output  1  state_out holds a valid result.
- out_ready  input  1  downstream accepts state_out this cycle.
- state_out  output  128  transformed state.

Behaviour:
- Byte map: byte k = state[127-8k -: 8] for k = 0..15. Byte 0 is the MSB byte.
- Layout is column-major: row r = k mod 4, column c = k div 4.
- Transform: out[r][c] = in[r][(c - r) mod 4].
  - Row 0 is unchanged.
  - Row 1 is rotated right by 1.
  - Row 2 is rotated right by 2.
  - Row 3 is rotated right by 3.
- The transform is purely combinational. It is captured in a single output register, giving latency 1 cycle from accept to out_valid.
- in_ready = !out_valid || out_ready (combinational).
- An accept occurs when in_valid && in_ready. On accept, state_out <= transform(state_in) and out_valid <= 1.
- If out_valid && out_ready and there is no accept, out_valid <= 0 and state_out holds.
- Accept and drain in the same cycle is allowed. The new result replaces the old, out_valid stays 1, and throughput is 1 state per cycle.
- Backpressure: while out_valid && !out_ready, state_out and out_valid hold, in_ready = 0, and state_in is ignored.
- Reset, when rst = 1 at a clock edge:
  - out_valid <= 0.
  - state_out <= 0 if RESET_CLEARS_DATA = 1, otherwise held.
  - Reset overrides any accept in the same cycle.
  - A result in flight during reset is discarded.
- After reset, in_ready = 1.
- When out_valid = 0, the value on state_out has no meaning and must not be checked.
- No X propagation from state_in when in_valid = 0: the register is not loaded.

Optional Feature:
- Macro FWD_SHIFT_ROWS_EN.
- When defined:
  - Adds input port inverse (1 bit), sampled with state_in at accept.
  - inverse = 1 selects the InvShiftRows transform above.
  - inverse = 0 selects forward ShiftRows: out[r][c] = in[r][(c + r) mod 4].
- When undefined: no inverse port; the transform is always InvShiftRows.
- Timing and handshake are identical in both builds.

Test Plan:
- Basic vector 1: rst 2 cycles; in_valid=1, state_in=23456701cdef89ab6701234589abcdef, out_ready=1 -> next cycle out_valid=1, state_out=23ab23abcd45cd4567ef67ef89018901.
- Basic vector 2: state_in=cdef01ab6789234501abcdef23456789 -> state_out=cd45cd4567ef67ef0189018923ab23ab one cycle later.
- Identity/streaming: state_in=0 then all-ones then 000102030405060708090a0b0c0d0e0f on back-to-back cycles with out_ready=1.
  - Outputs 0, all-ones, then 000d0a0704010e0b0805020f0c090603 on consecutive cycles.
  - in_ready stays 1 throughout.
- Backpressure: load vector 1, hold out_ready=0 for 3 cycles while presenting vector 2.
  - in_ready=0 during the stall.
  - state_out holds 23ab23ab... for the whole stall.
  - Raise out_ready: vector 2 is accepted that cycle and its result appears next cycle.
- Reset mid-operation: out_valid=1 holding vector 1 result; assert rst with in_valid=1 -> next cycle out_valid=0, and state_out=0 (RESET_CLEARS_DATA=1).
- FWD_SHIFT_ROWS_EN build: inverse=0, state_in=23ab23abcd45cd4567ef67ef89018901 -> state_out=23456701cdef89ab6701234589abcdef (round trip). inverse=1 reproduces the vector 1 result.
